sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that funnels N requester ports onto the single
// control port of an SDRAM core, keeping exactly one transaction in flight.
//
// state   | meaning
// S_IDLE  | no transaction held; arbitrate and accept one request
// S_ISSUE | captured request presented to the core until m_rdy
// S_WAIT  | core owns the request; wait for its completion pulse
module sdram_port_arbiter #(
  parameter  int N_PORTS    = 4,
  parameter  int ADDR_WIDTH = 25,
  parameter  int DATA_WIDTH = 16,
  localparam int WORD_LEN   = DATA_WIDTH / 8,
  localparam int ID_W       = $clog2(N_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               p_rd,
  input  logic [N_PORTS*WORD_LEN-1:0]      p_wr,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    p_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    p_write_data,
  output logic [N_PORTS-1:0]               p_accept,
  output logic [N_PORTS-1:0]               p_rvalid,
  output logic [N_PORTS-1:0]               p_wvalid,
  output logic [DATA_WIDTH-1:0]            p_read_data,
  output logic                             m_rd,
  output logic [WORD_LEN-1:0]              m_wr,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_write_data,
  input  logic                             m_rdy,
  input  logic                             m_rvalid,
  input  logic                             m_wvalid,
  input  logic [DATA_WIDTH-1:0]            m_read_data,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       grant_q;
  logic                  rd_q;
  logic [WORD_LEN-1:0]   wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [N_PORTS-1:0]    req;
  logic                  found;
  logic [ID_W-1:0]       sel;
  logic                  sel_rd;
  logic [WORD_LEN-1:0]   sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A port requests when its read line or any of its write strobes is set.
  always_comb begin
    req = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req[i] = p_rd[i] | (|p_wr[i*WORD_LEN +: WORD_LEN]);
    end
  end

  // Round-robin pick: first requesting port at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(ptr) + k) % N_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Fields of the selected port; a read wins over simultaneous write strobes.
  always_comb begin
    sel_rd    = p_rd[sel];
    sel_wr    = sel_rd ? '0 : p_wr[int'(sel)*WORD_LEN +: WORD_LEN];
    sel_addr  = p_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = p_write_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Sequencer: capture in IDLE, hand to core in ISSUE, await completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            rd_q    <= sel_rd;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            grant_q <= sel;
            ptr     <= (int'(sel) == N_PORTS - 1) ? '0 : sel + ID_W'(1);
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_rdy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_rvalid || m_wvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-port pulses; everything is held at zero while reset is asserted.
  always_comb begin
    p_accept    = '0;
    p_rvalid    = '0;
    p_wvalid    = '0;
    p_read_data = '0;
    if (!rst) begin
      if (state == S_IDLE && found) p_accept[sel] = 1'b1;
      if (state == S_WAIT && m_rvalid) begin
        p_rvalid[grant_q] = 1'b1;
        p_read_data       = m_read_data;
      end
      if (state == S_WAIT && m_wvalid) p_wvalid[grant_q] = 1'b1;
    end
  end

  // Core-side request lines are only live in ISSUE; address/data just hold.
  always_comb begin
    m_rd         = !rst && (state == S_ISSUE) && rd_q;
    m_wr         = (!rst && state == S_ISSUE) ? wr_q : '0;
    m_addr       = rst ? '0 : addr_q;
    m_write_data = rst ? '0 : wdata_q;
    busy         = !rst && (state != S_IDLE);
    grant_id     = rst ? '0 : grant_q;
  end

endmodule
